// File: rtl/noc_pkg.sv
// Shared NoC definitions for the local output-port controller.
//   - flit_type_e : flit type carried in the top two bits of every flit
//   - CS_*        : crossbar select codes driven on cs_sel_o
//   - state_e     : packet-lock state of the output-port FSM
//   - get_flit_type() : decode helper for the two type bits
package noc_pkg;

  localparam int unsigned FLIT_W_DEFAULT = 34;

  typedef enum logic [1:0] {
    BODY   = 2'b00,
    HEAD   = 2'b01,
    TAIL   = 2'b10,
    SINGLE = 2'b11
  } flit_type_e;

  localparam logic [2:0] CS_N    = 3'd0;
  localparam logic [2:0] CS_S    = 3'd1;
  localparam logic [2:0] CS_W    = 3'd2;
  localparam logic [2:0] CS_E    = 3'd3;
  localparam logic [2:0] CS_L    = 3'd4;
  localparam logic [2:0] CS_NONE = 3'd7;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  function automatic flit_type_e get_flit_type(input logic [1:0] i_type_bits);
    return flit_type_e'(i_type_bits);
  endfunction

endpackage

// File: rtl/flit_out_reg.sv
// One-entry valid/ready output register feeding the local PE.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   i_load      : request to capture i_data (honoured only when o_space)
//   i_data      : flit to capture
//   i_ready     : downstream accepts the flit currently held
//   o_valid     : register holds a flit
//   o_data      : held flit, stable while o_valid & !i_ready
//   o_space     : register can take a new flit this cycle
module flit_out_reg #(
  parameter int unsigned FLIT_W = 34
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic [FLIT_W-1:0] i_data,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [FLIT_W-1:0] o_data,
  output logic              o_space
);

  logic              r_valid;
  logic [FLIT_W-1:0] r_data;
  logic              w_space;

  // Empty, or the held flit leaves this cycle: a new one can enter.
  assign w_space = !r_valid | i_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load && w_space) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_space = w_space;

endmodule

// File: rtl/l_output_port_ctrl.sv
// Local (ejection) output-port controller.
// Takes the one-hot grant of the local round-robin arbiter, locks the
// crossbar path to the winning input (N/S/W/E) for a whole packet, and
// streams its flits through a one-entry output register to the local PE.
// A one-cycle change-order pulse tells the arbiter to rotate when a packet
// completes.
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   rrp_l_priority_{n,s,w,e}_i      : arbiter grant (one-hot expected)
//   {n,s,w,e}_flit_valid_i / data_i : input-buffer head flit
//   {n,s,w,e}_flit_pop_o            : dequeue strobe to the input buffers
//   l_flit_valid_o / data_o         : flit to the local PE
//   l_flit_ready_i                  : local PE accepts the flit
//   cs_sel_o                        : crossbar select (0=N 1=S 2=W 3=E 7=none)
//   rr_register_change_order_o      : arbiter rotate pulse
//   busy_o                          : a packet is locked
//   pkt_err_o                       : sticky protocol / watchdog error
// Build option: define L_OUTPUT_PORT_CTRL_WATCHDOG_EN to drop the lock once
// MAX_PKT_FLITS flits have passed without a tail.
module l_output_port_ctrl
  import noc_pkg::*;
#(
  parameter int unsigned FLIT_W        = FLIT_W_DEFAULT,
  parameter int unsigned MAX_PKT_FLITS = 16,
  parameter int unsigned CNT_W         = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rrp_l_priority_n_i,
  input  logic              rrp_l_priority_s_i,
  input  logic              rrp_l_priority_w_i,
  input  logic              rrp_l_priority_e_i,
  input  logic              n_flit_valid_i,
  input  logic              s_flit_valid_i,
  input  logic              w_flit_valid_i,
  input  logic              e_flit_valid_i,
  input  logic [FLIT_W-1:0] n_flit_data_i,
  input  logic [FLIT_W-1:0] s_flit_data_i,
  input  logic [FLIT_W-1:0] w_flit_data_i,
  input  logic [FLIT_W-1:0] e_flit_data_i,
  output logic              n_flit_pop_o,
  output logic              s_flit_pop_o,
  output logic              w_flit_pop_o,
  output logic              e_flit_pop_o,
  output logic              l_flit_valid_o,
  output logic [FLIT_W-1:0] l_flit_data_o,
  input  logic              l_flit_ready_i,
  output logic [2:0]        cs_sel_o,
  output logic              rr_register_change_order_o,
  output logic              busy_o,
  output logic              pkt_err_o
);

  localparam bit PARAMS_OK = (MAX_PKT_FLITS >= 2) && ((64'd1 << CNT_W) > MAX_PKT_FLITS);

  if (!PARAMS_OK) begin : g_bad_params
    $error("l_output_port_ctrl: need MAX_PKT_FLITS >= 2 and 2**CNT_W > MAX_PKT_FLITS");
  end

`ifdef L_OUTPUT_PORT_CTRL_WATCHDOG_EN
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_PKT_FLITS);
`endif

  state_e            r_state, w_state_d;
  logic [2:0]        r_sel, w_sel_d;
  logic [CNT_W-1:0]  r_cnt, w_cnt_d, w_cnt_inc;
  logic              r_err;

  logic [3:0]        w_gnt;
  logic [2:0]        w_gnt_sel;
  logic              w_gnt_multi;
  logic [2:0]        w_sel;
  logic              w_sel_valid;
  logic [FLIT_W-1:0] w_sel_data;
  flit_type_e        w_type;
  logic              w_space;
  logic              w_pop, w_pop_g;
  logic              w_chg;
  logic              w_err_set;

  // Grant resolution: fixed N > S > W > E if the arbiter ever raises more
  // than one bit; that case is also flagged as an error.
  assign w_gnt = {rrp_l_priority_e_i, rrp_l_priority_w_i, rrp_l_priority_s_i,
                  rrp_l_priority_n_i};

  always_comb begin
    w_gnt_sel = CS_NONE;
    if (w_gnt[0]) begin
      w_gnt_sel = CS_N;
    end else if (w_gnt[1]) begin
      w_gnt_sel = CS_S;
    end else if (w_gnt[2]) begin
      w_gnt_sel = CS_W;
    end else if (w_gnt[3]) begin
      w_gnt_sel = CS_E;
    end
  end

  assign w_gnt_multi = (w_gnt & (w_gnt - 4'd1)) != 4'd0;

  // While locked the latched select wins; grants are not looked at.
  assign w_sel = (r_state == ACTIVE) ? r_sel : w_gnt_sel;

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_data  = '0;
    case (w_sel)
      CS_N: begin
        w_sel_valid = n_flit_valid_i;
        w_sel_data  = n_flit_data_i;
      end
      CS_S: begin
        w_sel_valid = s_flit_valid_i;
        w_sel_data  = s_flit_data_i;
      end
      CS_W: begin
        w_sel_valid = w_flit_valid_i;
        w_sel_data  = w_flit_data_i;
      end
      CS_E: begin
        w_sel_valid = e_flit_valid_i;
        w_sel_data  = e_flit_data_i;
      end
      default: begin
        w_sel_valid = 1'b0;
        w_sel_data  = '0;
      end
    endcase
  end

  assign w_type = get_flit_type(w_sel_data[FLIT_W-1 -: 2]);

  // Counter saturates instead of wrapping so a runaway packet never aliases
  // back to a small count.
  assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);

  always_comb begin
    w_state_d = r_state;
    w_sel_d   = r_sel;
    w_cnt_d   = r_cnt;
    w_pop     = 1'b0;
    w_chg     = 1'b0;
    w_err_set = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_gnt_multi) begin
          w_err_set = 1'b1;
        end
        // w_sel_valid can only be high when some grant bit is set.
        if (w_sel_valid) begin
          unique case (w_type)
            HEAD: begin
              if (w_space) begin
                w_pop     = 1'b1;
                w_sel_d   = w_gnt_sel;
                w_cnt_d   = CNT_W'(1);
                w_state_d = ACTIVE;
              end
            end
            SINGLE: begin
              if (w_space) begin
                w_pop = 1'b1;
                w_chg = 1'b1;
              end
            end
            default: begin
              // Body or tail without a preceding head: leave it in the buffer.
              w_err_set = 1'b1;
            end
          endcase
        end
      end
      ACTIVE: begin
        if (w_sel_valid && w_space) begin
          w_pop   = 1'b1;
          w_cnt_d = w_cnt_inc;
          if (w_type == TAIL) begin
            w_chg     = 1'b1;
            w_state_d = IDLE;
            w_cnt_d   = '0;
          end else begin
            if (w_type != BODY) begin
              w_err_set = 1'b1;
            end
`ifdef L_OUTPUT_PORT_CTRL_WATCHDOG_EN
            if (w_cnt_inc == CNT_LIMIT) begin
              w_chg     = 1'b1;
              w_err_set = 1'b1;
              w_state_d = IDLE;
              w_cnt_d   = '0;
            end
`endif
          end
        end
      end
      default: begin
        w_state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_sel   <= CS_NONE;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_sel   <= w_sel_d;
      r_cnt   <= w_cnt_d;
      r_err   <= r_err | w_err_set;
    end
  end

  // No dequeue and no arbiter pulse while reset is held, even mid-packet.
  assign w_pop_g = w_pop & !reset;

  flit_out_reg #(
    .FLIT_W (FLIT_W)
  ) u_flit_out_reg (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_pop_g),
    .i_data  (w_sel_data),
    .i_ready (l_flit_ready_i),
    .o_valid (l_flit_valid_o),
    .o_data  (l_flit_data_o),
    .o_space (w_space)
  );

  assign n_flit_pop_o = w_pop_g & (w_sel == CS_N);
  assign s_flit_pop_o = w_pop_g & (w_sel == CS_S);
  assign w_flit_pop_o = w_pop_g & (w_sel == CS_W);
  assign e_flit_pop_o = w_pop_g & (w_sel == CS_E);

  assign rr_register_change_order_o = w_chg & !reset;
  assign cs_sel_o                   = (r_state == ACTIVE) ? r_sel : CS_NONE;
  assign busy_o                     = (r_state == ACTIVE);
  assign pkt_err_o                  = r_err;

endmodule

// File: tb/tb_l_output_port_ctrl.sv
`timescale 1ns/1ps
module tb_l_output_port_ctrl;

  localparam int unsigned FLIT_W = 34;
  localparam int unsigned CNT_W  = 5;
`ifdef L_OUTPUT_PORT_CTRL_WATCHDOG_EN
  localparam int unsigned MAX_FLITS = 4;
`else
  localparam int unsigned MAX_FLITS = 16;
`endif

  typedef logic [FLIT_W-1:0] flit_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  gnt;
  logic [3:0]  fv;
  flit_t       fd [4];
  logic        pop_n, pop_s, pop_w, pop_e;
  logic [3:0]  pops;
  logic        l_valid;
  flit_t       l_data;
  logic        l_ready;
  logic [2:0]  cs_sel;
  logic        chg;
  logic        busy;
  logic        err;

  assign pops = {pop_e, pop_w, pop_s, pop_n};

  always #5 clk = ~clk;

  l_output_port_ctrl #(
    .FLIT_W        (FLIT_W),
    .MAX_PKT_FLITS (MAX_FLITS),
    .CNT_W         (CNT_W)
  ) dut (
    .clk                        (clk),
    .reset                      (reset),
    .rrp_l_priority_n_i         (gnt[0]),
    .rrp_l_priority_s_i         (gnt[1]),
    .rrp_l_priority_w_i         (gnt[2]),
    .rrp_l_priority_e_i         (gnt[3]),
    .n_flit_valid_i             (fv[0]),
    .s_flit_valid_i             (fv[1]),
    .w_flit_valid_i             (fv[2]),
    .e_flit_valid_i             (fv[3]),
    .n_flit_data_i              (fd[0]),
    .s_flit_data_i              (fd[1]),
    .w_flit_data_i              (fd[2]),
    .e_flit_data_i              (fd[3]),
    .n_flit_pop_o               (pop_n),
    .s_flit_pop_o               (pop_s),
    .w_flit_pop_o               (pop_w),
    .e_flit_pop_o               (pop_e),
    .l_flit_valid_o             (l_valid),
    .l_flit_data_o              (l_data),
    .l_flit_ready_i             (l_ready),
    .cs_sel_o                   (cs_sel),
    .rr_register_change_order_o (chg),
    .busy_o                     (busy),
    .pkt_err_o                  (err)
  );

  int    n_checks = 0;
  int    n_fail   = 0;
  flit_t bufq [4][$];   // model of the four input buffers
  flit_t exp_q [$];     // scoreboard: flits the PE must see, in order
  int    exp_sel  = -1; // required cs_sel while busy (-1 = not checked)
  int    chg_cnt  = 0;
  int    exp_pkts = 0;
  bit    rand_rdy = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic report_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  task automatic refresh();
    for (int i = 0; i < 4; i++) begin
      fv[i] = (bufq[i].size() != 0);
      fd[i] = fv[i] ? bufq[i][0] : '0;
    end
  endtask

  function automatic flit_t mk(input logic [1:0] t);
    logic [63:0] r;
    r = {$urandom, $urandom};
    return {t, r[FLIT_W-3:0]};
  endfunction

  // Packet: single if len==1, else head, bodies, and a tail when has_tail.
  // Only the first nexp flits are expected at the PE.
  task automatic load_pkt(input int port, input int len, input bit has_tail, input int nexp);
    flit_t f;
    for (int i = 0; i < len; i++) begin
      if (len == 1)                    f = mk(2'b11);
      else if (i == 0)                 f = mk(2'b01);
      else if (i == len - 1 && has_tail) f = mk(2'b10);
      else                             f = mk(2'b00);
      bufq[port].push_back(f);
      if (i < nexp) exp_q.push_back(f);
    end
    refresh();
  endtask

  // Input-buffer model: dequeue the head whenever the DUT strobes pop.
  initial begin : buffer_model
    logic [3:0] p;
    forever begin
      @(negedge clk);
      p = pops;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (p[i]) begin
          if (bufq[i].size() == 0) report_fail("pop_of_empty_buffer");
          else void'(bufq[i].pop_front());
        end
      end
      refresh();
    end
  end

  // Monitor: compares every accepted flit against the scoreboard.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (chg) chg_cnt++;
        if (l_valid && l_ready) begin
          if (exp_q.size() == 0) report_fail("unexpected_flit");
          else check("flit_data", l_data, exp_q.pop_front());
        end
        if (busy && exp_sel >= 0) check("cs_sel_active", cs_sel, exp_sel);
      end
    end
  end

  initial begin : time_limit
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  task automatic step();
    @(posedge clk);
    #2;
    l_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
  endtask

  task automatic drain();
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < 300) begin
      step();
      cyc++;
    end
    if (exp_q.size() != 0) report_fail("drain_timeout");
    repeat (2) step();
  endtask

  task automatic check_reset_vals(input string tag);
    @(negedge clk);
    check({tag, "_valid"}, l_valid, 0);
    check({tag, "_data"}, l_data, 0);
    check({tag, "_cs_sel"}, cs_sel, 7);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_chg"}, chg, 0);
    check({tag, "_pops"}, pops, 0);
  endtask

  // Cycle-exact script; bit c of each vector is the expectation in cycle c+1.
  task automatic scripted(input int port, input int len, input int ncyc,
                          input logic [15:0] rdy, input logic [15:0] pop,
                          input logic [15:0] chgv, input logic [15:0] vld,
                          input logic [15:0] bsy, input string tag);
    gnt      = 4'(1 << port);
    exp_sel  = port;
    rand_rdy = 1'b0;
    exp_pkts++;
    load_pkt(port, len, 1'b1, len);
    for (int c = 0; c < ncyc; c++) begin
      l_ready = rdy[c];
      @(negedge clk);
      check({tag, "_pop"}, pops[port], pop[c]);
      check({tag, "_chg"}, chg, chgv[c]);
      check({tag, "_valid"}, l_valid, vld[c]);
      check({tag, "_busy"}, busy, bsy[c]);
      if (l_valid && !l_ready && exp_q.size() != 0) check({tag, "_hold_data"}, l_data, exp_q[0]);
      @(posedge clk);
      #2;
      if (c == 0) gnt = 4'b0;
    end
    drain();
  endtask

  task automatic send_packet(input int port, input int len);
    int cyc;
    int q;
    gnt     = 4'(1 << port);
    exp_sel = port;
    exp_pkts++;
    load_pkt(port, len, 1'b1, len);
    cyc = 0;
    while (bufq[port].size() != 0 && cyc < 300) begin
      step();
      cyc++;
      // After the head has gone, wiggle the grant: it must not matter.
      if (bufq[port].size() < len) begin
        q   = $urandom_range(0, 4);
        gnt = (q == 4 || q == port) ? 4'b0 : 4'(1 << q);
      end
    end
    if (bufq[port].size() != 0) report_fail("pkt_timeout");
    gnt = 4'b0;
    drain();
  endtask

  initial begin : stimulus
    int cyc;
    int popcnt;
    reset   = 1'b1;
    gnt     = 4'b0;
    l_ready = 1'b1;
    refresh();
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    check_reset_vals("reset");
    @(posedge clk);
    #2;

    // W head/body/tail, PE always ready.
    scripted(2, 3, 5, 16'h1f, 16'b00111, 16'b00100, 16'b01110, 16'b00110, "w3");
    // E single flit.
    scripted(3, 1, 3, 16'h7, 16'b001, 16'b001, 16'b010, 16'b000, "e1");
    // N 4-flit packet, PE stalls three cycles mid-packet.
    scripted(0, 4, 9, 16'b111100011, 16'b001100011, 16'b001000000, 16'b011111110,
             16'b001111110, "n4bp");
    check("chg_after_directed", chg_cnt, exp_pkts);

    // Random packets with random backpressure.
    rand_rdy = 1'b1;
    for (int k = 0; k < 12; k++) send_packet($urandom_range(0, 3), $urandom_range(1, 4));
    rand_rdy = 1'b0;
    check("chg_after_random", chg_cnt, exp_pkts);
    check("err_clean", err, 0);

    // N and S both granted with heads: N must win, S must wait.
    exp_sel = 0;
    exp_pkts += 2;
    load_pkt(0, 3, 1'b1, 3);
    load_pkt(1, 2, 1'b1, 2);
    gnt = 4'b0011;
    cyc = 0;
    while (bufq[0].size() != 0 && cyc < 50) begin
      @(negedge clk);
      check("multi_s_pop", pops[1], 0);
      @(posedge clk);
      #2;
      cyc++;
      if (bufq[0].size() < 3) gnt = 4'b0010;
    end
    if (bufq[0].size() != 0) report_fail("multi_n_timeout");
    check("multi_s_untouched", bufq[1].size(), 2);
    exp_sel = 1;
    cyc = 0;
    while (bufq[1].size() != 0 && cyc < 50) begin
      step();
      cyc++;
    end
    gnt = 4'b0;
    drain();
    check("multi_err", err, 1);
    check("chg_after_multi", chg_cnt, exp_pkts);

    // Reset in the middle of a 5-flit W packet, after 2 pops.
    exp_sel = 2;
    gnt     = 4'b0100;
    load_pkt(2, 5, 1'b1, 5);
    cyc = 0;
    while (bufq[2].size() > 3 && cyc < 50) begin
      step();
      cyc++;
    end
    check("rst_two_popped", bufq[2].size(), 3);
    reset   = 1'b1;
    gnt     = 4'b0;
    exp_sel = -1;
    bufq[2].delete();
    refresh();
    @(posedge clk);
    #2;
    reset = 1'b0;
    exp_q.delete();
    check_reset_vals("midpkt_reset");
    @(posedge clk);
    #2;
    send_packet(2, 3);
    check("post_reset_err", err, 0);
    check("chg_after_reset", chg_cnt, exp_pkts);

`ifdef L_OUTPUT_PORT_CTRL_WATCHDOG_EN
    // 6 flits, no tail: only MAX_FLITS pops, then forced release.
    exp_sel = 3;
    exp_pkts++;
    gnt = 4'b1000;
    load_pkt(3, 6, 1'b0, MAX_FLITS);
    popcnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (pops[3]) begin
        popcnt++;
        if (popcnt == MAX_FLITS) check("wd_chg_pulse", chg, 1);
      end
      @(posedge clk);
      #2;
    end
    check("wd_pop_count", popcnt, MAX_FLITS);
    check("wd_left_in_buffer", bufq[3].size(), 6 - MAX_FLITS);
    check("wd_busy", busy, 0);
    check("wd_cs_sel", cs_sel, 7);
    check("wd_err", err, 1);
    gnt = 4'b0;
    bufq[3].delete();
    refresh();
    drain();
    check("chg_after_wd", chg_cnt, exp_pkts);
`else
    // No limit without the watchdog: a 40-flit packet goes through whole.
    rand_rdy = 1'b1;
    send_packet(0, 40);
    rand_rdy = 1'b0;
    check("long_pkt_err", err, 0);
    check("chg_after_long", chg_cnt, exp_pkts);
`endif

    // Body flit presented in IDLE: never popped, error raised.
    exp_sel = -1;
    bufq[1].push_back(mk(2'b00));
    refresh();
    gnt = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("idle_body_pop", pops[1], 0);
      @(posedge clk);
      #2;
    end
    check("idle_body_err", err, 1);
    gnt = 4'b0;
    bufq[1].delete();
    refresh();
    repeat (2) step();
    check("final_chg", chg_cnt, exp_pkts);
    check("final_scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/l_output_port_ctrl.md
Name: l_output_port_ctrl

Overview:
- Local (ejection) output-port controller. Sits directly downstream of the local round-robin arbiter processor.
- Consumes the arbiter's one-hot grant, locks the local crossbar path to the winning input (N/S/W/E) for a whole packet, and streams flits through a one-entry output register to the local PE.
- Pulses the arbiter's change-order input on packet completion so the next arbitration rotates.

Parameters:
- FLIT_W, 34, flit width in bits; bits [FLIT_W-1:FLIT_W-2] are the flit type.
- MAX_PKT_FLITS, 16, watchdog limit on flits per packet; must be >= 2.
- CNT_W, 5, flit counter width; must satisfy 2^CNT_W > MAX_PKT_FLITS.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- rrp_l_priority_n_i / _s_i / _w_i / _e_i  in  1 each  arbiter grant, one-hot
- n_flit_valid_i / s_ / w_ / e_  in  1 each  input-buffer head flit valid
- n_flit_data_i / s_ / w_ / e_  in  FLIT_W each  input-buffer head flit
- n_flit_pop_o / s_ / w_ / e_  out  1 each  dequeue strobe to input buffer
- l_flit_valid_o  out  1  output flit valid
- l_flit_data_o  out  FLIT_W  output flit
- l_flit_ready_i  in  1  local PE accepts flit
- cs_sel_o  out  3  crossbar select: 0=N 1=S 2=W 3=E 7=none
- rr_register_change_order_o  out  1  one-cycle pulse to the arbiter
- busy_o  out  1  high while a packet is locked
- pkt_err_o  out  1  sticky protocol/watchdog error

Behaviour:
- Reset: one clock, synchronous, active-high. All outputs 0 except cs_sel_o = 7. State = IDLE, counter = 0, output register invalid. Reset mid-packet drops the lock and the buffered flit; no pops.
- Flit type: 01 = head, 00 = body, 10 = tail, 11 = single.
- space = !l_flit_valid_o | l_flit_ready_i.
- Pop/transfer occurs when space and the selected input is valid. The flit is registered and appears on l_flit_data_o the next cycle, so latency = 1. Data is held stable while l_flit_valid_o & !l_flit_ready_i.
- Grant resolution: if more than one grant bit is set, fixed order N > S > W > E; pkt_err_o is also set.
- IDLE:
  - cs_sel_o = 7.
  - Granted port valid with a head flit and space: pop, latch sel, counter = 1, go to ACTIVE.
  - Granted port valid with a single flit and space: pop, pulse change_order, stay in IDLE.
  - Granted port valid with a body or tail flit: no pop, set pkt_err_o.
  - No grant: nothing happens.
- ACTIVE:
  - cs_sel_o = latched sel; grant inputs are ignored.
  - Each transfer increments the counter.
  - Tail transfer: pulse change_order in the same cycle as the pop, go to IDLE.
  - Head or single seen while ACTIVE: still forwarded, set pkt_err_o.
- Back-to-back: the arbiter updates on the same edge as the tail transfer, so a new grant is acted on the cycle after the tail (zero-bubble for ready PE).
- Output backpressure: no pop while !space; state and counter are held.
- busy_o = (state == ACTIVE).

Optional Feature:
- Macro: L_OUTPUT_PORT_CTRL_WATCHDOG_EN.
- Defined:
  - In ACTIVE, if the counter reaches MAX_PKT_FLITS without a tail, force IDLE at the end of that cycle.
  - Pulse change_order and set pkt_err_o.
  - Flits remaining in the input buffer are later rejected in IDLE as non-head.
- Undefined: no counter limit; counter saturates at 2^CNT_W-1 and the lock is held until a tail arrives.

Decomposition:
- Package noc_pkg holds:
  - flit-type enum (HEAD, BODY, TAIL, SINGLE) and the FLIT_W default;
  - cs_sel constants (CS_N=0 … CS_L=4, CS_NONE=7);
  - the state enum (IDLE, ACTIVE).
- One sub-module, flit_out_reg: a one-entry valid/ready output register with space logic.
- Grant resolution and the FSM stay in the top module.

Test Plan:
- Reset then W grant; W presents head, body, tail with PE ready -> pops on cycles 1–3; l_flit_valid_o on cycles 2–4; cs_sel_o=2 while ACTIVE; change_order pulses on cycle 3 only.
- E single flit with E grant -> one pop, change_order pulsed in the same cycle, busy_o stays 0, flit out 1 cycle later.
- N 4-flit packet with l_flit_ready_i low for 3 cycles mid-packet -> no pops while output is full, data held stable, counter and sel held, all 4 flits delivered in order.
- N and S grants both high, both holding heads -> N wins, pkt_err_o=1; mid-packet S grant change ignored.
- Reset asserted in ACTIVE after 2 of 5 flits -> next cycle all outputs at reset values, then IDLE accepts a new head.
- Watchdog build, MAX_PKT_FLITS=4, 6-flit packet without a tail -> 4 pops, forced IDLE, change_order pulse, pkt_err_o=1, next body flit not popped.
